dpram_arbiter: RTL and testbench
================================

# dpram_arbiter

- Round-robin arbiter that shares one `Dual_Port_RAM` instance (8-bit data, 256 locations) among `N_REQ` requesters.
- Grants up to two accesses per cycle and maps them onto ports A and B.
- Drives the RAM in dual-port mode only, and only with command combinations whose RAM behaviour is well defined.
- Sits between client logic and the RAM, and registers returned read data back to the owning requester.

## Interface
- `N_REQ`, 4: number of requesters; legal values 2..8.
- `AW`, 8: address width; must match the RAM.
- `DW`, 8: data width; must match the RAM.
- `Clk` in 1: the one clock. The arbiter uses the rising edge; the RAM uses the falling edge of the same net.
- `Clr` in 1: synchronous, active-high reset.
- `req` in N_REQ: per-requester access request.
- `we` in N_REQ: 1 = write, 0 = read.
- `addr` in N_REQ*AW: packed addresses; requester i occupies bits [i*AW +: AW].
- `wdata` in N_REQ*DW: packed write data.
- `gnt` out N_REQ: combinational grant; an access transfers on the rising edge where `req[i]&gnt[i]`.
- `rvalid` out N_REQ: one-cycle pulse marking returned read data.
- `rdata` out N_REQ*DW: packed read data; valid only while `rvalid[i]` is high.
- `ram_SPM` out 1: tied 0.
- `ram_WeA`, `ram_WeB` out 1: RAM write enables.
- `ram_addrA`, `ram_addrB` out AW: RAM addresses.
- `ram_dinA`, `ram_dinB` out DW: RAM write data.
- `ram_doutA`, `ram_doutB` in DW: RAM read data.

## Operation
- A requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`. Dropping `req` before grant is allowed; the request is withdrawn.
- Round-robin pointer `rr` (log2 N_REQ bits, reset 0). Requesters are scanned in order rr, rr+1, … mod N_REQ.
- **First grant (G1):** the first requester in scan order with `req` set.
- **Second grant (G2):** the next requester after G1 in scan order with `req` set, skipping any requester where both it and G1 are writes to the same address.
- A skipped requester stays pending; it is not dropped.
- **Port mapping:**
  - Exactly one write among {G1, G2}: the write goes on port A (`ram_WeA`=1), the read on port B, `ram_WeB`=0.
  - Two writes: G1 on A, G2 on B, both enables 1.
  - Two reads: G1 on A, G2 on B, both enables 0.
  - G1 only: G1 on port A. Port B idles as a read of address 0 with its result discarded.
  - No grant: both enables 0, addresses 0.
- `{ram_WeA,ram_WeB}` = 01 is never driven.
- **Read-during-write, same cycle, same address (A write, B read):** the read returns the pre-write contents.
- **Pointer update:** `rr` ← (index of the last-granted requester in scan order) + 1 mod N_REQ. It is unchanged when nothing is granted.
- **Read return:** a 2-deep tag pipeline records, per port, the owning requester index and a read flag. It routes `ram_doutA`/`ram_doutB` to the owner's `rdata` slice and pulses that requester's `rvalid`.
- A requester may be granted again while its earlier read is still in flight. Returns stay in order per requester.
- One requester can hold at most one grant per cycle.

## Timing
- `gnt` is combinational from `req`/`we`/`addr`/`rr` in the same cycle, with no wait states when uncontended.
- All `ram_*` outputs are registered at the grant edge k. The RAM executes at the falling edge between k and k+1.
- Read data is captured at edge k+1, so `rvalid[i]` is high in the cycle after k+1.
- Read latency is 2 rising edges from the grant edge; sustained throughput is two accesses per cycle.
- **Reset values:**
  - `gnt` = 0 while `Clr` is high.
  - `rvalid` = 0, `rdata` = 0.
  - `ram_WeA` = `ram_WeB` = 0; `ram_addr*` = 0; `ram_din*` = 0; `ram_SPM` = 0.
  - `rr` = 0; tag pipeline cleared.
- **Reset mid-operation:** reads granted before the `Clr` edge never produce `rvalid`. No RAM write is issued in the cycle after the `Clr` edge.
- The arbiter does not clear RAM contents.

## Test plan
- **Reset:** `Clr`=1 for 2 cycles with all `req`=1 → `gnt`=0, `rvalid`=0, `ram_WeA`/`ram_WeB`=0; after release, first grants go to requesters 0 and 1.
- **Single write then read:** req0 writes 0xA5 to address 0x10; two cycles later req0 reads 0x10 → `gnt[0]` immediate, `rvalid[0]` exactly 2 edges after the read grant, `rdata[0]`=0xA5.
- **Same-address write conflict:** req1 and req2 both write to 0x20 (0x11, 0x22) with `rr`=1 → only `gnt[1]` in cycle 1; `gnt[2]` next cycle; a later read of 0x20 returns 0x22.
- **Mixed pair:** req0 reads 0x30 (holding 0x77) while req3 writes 0x99 to 0x30 in the same cycle → write on port A, read on port B, `rdata[0]`=0x77, `{WeA,WeB}`=10; a subsequent read returns 0x99.
- **Fairness:** all 4 requesters issue continuous reads → grant pairs (0,1), (2,3), (0,1)…; every requester gets exactly one grant per 2 cycles; no `{WeA,WeB}`=01 ever appears.
- **Reset mid-flight:** req2 is granted a read at edge k, then `Clr` is asserted at edge k+1 → `rvalid[2]` never pulses; `rr`=0 after reset.

Source files
------------

// File: rtl/dpram_arbiter.sv
// dpram_arbiter: round-robin arbiter granting up to two accesses per cycle onto a shared dual-port RAM
// Ports:
//   Clk, Clr                 clock (rising edge here, RAM uses falling edge) and sync active-high reset
//   req, we, addr, wdata     per-requester request, write flag, packed address and packed write data
//   gnt                      combinational grant; transfer happens on the rising edge with req & gnt
//   rvalid, rdata            one-cycle read-return pulse and packed read data per requester
//   ram_SPM                  tied low, RAM always in dual-port mode
//   ram_WeA/B, ram_addrA/B   registered RAM commands
//   ram_dinA/B, ram_doutA/B  RAM write data out, RAM read data in
module dpram_arbiter #(
    parameter int N_REQ = 4,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic                Clk,
    input  logic                Clr,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    we,
    input  logic [N_REQ*AW-1:0] addr,
    input  logic [N_REQ*DW-1:0] wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rvalid,
    output logic [N_REQ*DW-1:0] rdata,
    output logic                ram_SPM,
    output logic                ram_WeA,
    output logic                ram_WeB,
    output logic [AW-1:0]       ram_addrA,
    output logic [AW-1:0]       ram_addrB,
    output logic [DW-1:0]       ram_dinA,
    output logic [DW-1:0]       ram_dinB,
    input  logic [DW-1:0]       ram_doutA,
    input  logic [DW-1:0]       ram_doutB
);
    localparam int IW = $clog2(N_REQ);
    logic [IW-1:0]       rr_q, rr_d, g1, g2, pa, pb, idx, last;
    logic                g1_v, g2_v, swap;
    logic                we_a_q, we_a_d, we_b_q, we_b_d;
    logic [AW-1:0]       addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [DW-1:0]       din_a_q, din_a_d, din_b_q, din_b_d;
    logic [IW-1:0]       own_a_q, own_a_d, own_b_q, own_b_d;
    logic                rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic [N_REQ-1:0]    rvalid_q, rvalid_d;
    logic [N_REQ*DW-1:0] rdata_q, rdata_d;

    always_comb begin
        g1   = '0;
        g2   = '0;
        g1_v = 1'b0;
        g2_v = 1'b0;
        idx  = '0;
        for (int o = 0; o < N_REQ; o++) begin
            idx = IW'((int'(rr_q) + o) % N_REQ);
            if (req[idx]) begin
                if (!g1_v) begin
                    g1_v = 1'b1;
                    g1   = idx;
                end else if (!g2_v && !(we[g1] && we[idx] && addr[g1*AW +: AW] == addr[idx*AW +: AW])) begin
                    // two writes to one address would be undefined in the RAM, so the later one waits
                    g2_v = 1'b1;
                    g2   = idx;
                end
            end
        end
        if (Clr) begin
            g1_v = 1'b0;
            g2_v = 1'b0;
        end
        // a lone write always rides port A so the RAM never sees WeA=0, WeB=1
        swap     = g2_v && !we[g1] && we[g2];
        pa       = swap ? g2 : g1;
        pb       = swap ? g1 : g2;
        last     = g2_v ? g2 : g1;
        rr_d     = g1_v ? IW'((int'(last) + 1) % N_REQ) : rr_q;
        gnt      = '0;
        if (g1_v) gnt[g1] = 1'b1;
        if (g2_v) gnt[g2] = 1'b1;
        we_a_d   = g1_v && we[pa];
        we_b_d   = g2_v && we[pb];
        addr_a_d = g1_v ? addr[pa*AW +: AW] : '0;
        addr_b_d = g2_v ? addr[pb*AW +: AW] : '0;
        din_a_d  = we_a_d ? wdata[pa*DW +: DW] : '0;
        din_b_d  = we_b_d ? wdata[pb*DW +: DW] : '0;
        own_a_d  = pa;
        own_b_d  = pb;
        rd_a_d   = g1_v && !we[pa];
        rd_b_d   = g2_v && !we[pb];
    end

    // RAM output from the previous falling edge is steered to whoever owned that port
    always_comb begin
        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (rd_a_q) begin
            rvalid_d[own_a_q]             = 1'b1;
            rdata_d[own_a_q*DW +: DW]     = ram_doutA;
        end
        if (rd_b_q) begin
            rvalid_d[own_b_q]             = 1'b1;
            rdata_d[own_b_q*DW +: DW]     = ram_doutB;
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            rr_q     <= '0;
            we_a_q   <= 1'b0;
            we_b_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            din_a_q  <= '0;
            din_b_q  <= '0;
            own_a_q  <= '0;
            own_b_q  <= '0;
            rd_a_q   <= 1'b0;
            rd_b_q   <= 1'b0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rr_q     <= rr_d;
            we_a_q   <= we_a_d;
            we_b_q   <= we_b_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            din_a_q  <= din_a_d;
            din_b_q  <= din_b_d;
            own_a_q  <= own_a_d;
            own_b_q  <= own_b_d;
            rd_a_q   <= rd_a_d;
            rd_b_q   <= rd_b_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign ram_SPM   = 1'b0;
    assign ram_WeA   = we_a_q;
    assign ram_WeB   = we_b_q;
    assign ram_addrA = addr_a_q;
    assign ram_addrB = addr_b_q;
    assign ram_dinA  = din_a_q;
    assign ram_dinB  = din_b_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
endmodule

// File: tb/tb_dpram_arbiter.sv
// tb_dpram_arbiter: scoreboard bench for dpram_arbiter with a behavioural RAM and reference arbiter
module tb_dpram_arbiter;
    localparam int N = 4;
    logic Clk = 1'b0;
    logic Clr = 1'b1;
    logic [N-1:0] req, we, gnt, rvalid;
    logic [N*8-1:0] addr, wdata, rdata;
    logic ram_SPM, ram_WeA, ram_WeB;
    logic [7:0] ram_addrA, ram_addrB, ram_dinA, ram_dinB, ram_doutA, ram_doutB;
    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int m_rr = 0;
    logic [N-1:0] m_g = '0;
    bit mix_chk = 1'b0;
    logic [7:0] mem [256];
    logic [7:0] m_mem [256];
    int q_due [N][$];
    logic [7:0] q_dat [N][$];

    dpram_arbiter #(.N_REQ(N), .AW(8), .DW(8)) dut (
        .Clk(Clk), .Clr(Clr), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_SPM(ram_SPM),
        .ram_WeA(ram_WeA), .ram_WeB(ram_WeB), .ram_addrA(ram_addrA), .ram_addrB(ram_addrB),
        .ram_dinA(ram_dinA), .ram_dinB(ram_dinB), .ram_doutA(ram_doutA), .ram_doutB(ram_doutB)
    );

    always #5 Clk = ~Clk;

    // falling-edge dual-port RAM; a read sees the contents before a same-edge write
    always @(negedge Clk) begin
        ram_doutA <= mem[ram_addrA];
        ram_doutB <= mem[ram_addrB];
        if (ram_WeA) mem[ram_addrA] <= ram_dinA;
        if (ram_WeB) mem[ram_addrB] <= ram_dinB;
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(int i, bit w, logic [7:0] a, logic [7:0] d);
        req[i] = 1'b1;
        we[i] = w;
        addr[i*8 +: 8] = a;
        wdata[i*8 +: 8] = d;
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
        if (mix_chk) begin
            chk("mix_WeA", 32'(ram_WeA), 1);
            chk("mix_WeB", 32'(ram_WeB), 0);
            chk("mix_addrA", 32'(ram_addrA), 32'h30);
            chk("mix_addrB", 32'(ram_addrB), 32'h30);
            chk("mix_dinA", 32'(ram_dinA), 32'h99);
            mix_chk = 1'b0;
        end
        #1;
        req = req & ~m_g;
        m_g = '0;
    endtask

    // reference: list requesters in round-robin order, take the first, then the first
    // later one that is not a same-address write pair with it
    task automatic evaluate();
        int order[$];
        int g1, g2, g;
        logic [N-1:0] exp_g;
        @(negedge Clk);
        g1 = -1;
        g2 = -1;
        exp_g = '0;
        if (Clr) m_rr = 0;
        else begin
            for (int o = 0; o < N; o++) if (req[(m_rr + o) % N]) order.push_back((m_rr + o) % N);
            if (order.size() > 0) g1 = order.pop_front();
            foreach (order[k])
                if (g2 < 0 && !(we[g1] && we[order[k]] && addr[g1*8 +: 8] == addr[order[k]*8 +: 8])) g2 = order[k];
        end
        if (g1 >= 0) exp_g[g1] = 1'b1;
        if (g2 >= 0) exp_g[g2] = 1'b1;
        chk("gnt", 32'(gnt), 32'(exp_g));
        m_g = exp_g;
        for (int j = 0; j < 2; j++) begin
            g = j ? g2 : g1;
            if (g >= 0 && !we[g]) begin
                q_due[g].push_back(edge_n + 2);
                q_dat[g].push_back(m_mem[addr[g*8 +: 8]]);
            end
        end
        for (int j = 0; j < 2; j++) begin
            g = j ? g2 : g1;
            if (g >= 0 && we[g]) m_mem[addr[g*8 +: 8]] = wdata[g*8 +: 8];
        end
        if (g2 >= 0) m_rr = (g2 + 1) % N;
        else if (g1 >= 0) m_rr = (g1 + 1) % N;
    endtask

    always begin
        @(posedge Clk);
        edge_n++;
        #1;
        chk("we_not_01", 32'({ram_WeA, ram_WeB} == 2'b01), 0);
        for (int i = 0; i < N; i++) begin
            if (rvalid[i]) begin
                if (q_due[i].size() == 0) chk($sformatf("rvalid%0d_unexpected", i), 32'(rvalid[i]), 0);
                else begin
                    chk($sformatf("rdata%0d", i), 32'(rdata[i*8 +: 8]), 32'(q_dat[i].pop_front()));
                    chk($sformatf("rlat%0d", i), edge_n, q_due[i].pop_front());
                end
            end else if (q_due[i].size() > 0 && q_due[i][0] <= edge_n) begin
                chk($sformatf("rvalid%0d_missing", i), 32'(rvalid[i]), 1);
                void'(q_due[i].pop_front());
                void'(q_dat[i].pop_front());
            end
        end
    end

    initial begin
        for (int a = 0; a < 256; a++) begin
            mem[a] = 8'h00;
            m_mem[a] = 8'h00;
        end
        req = '1;
        we = '0;
        addr = '0;
        wdata = '0;
        evaluate();
        next_cycle();
        evaluate();
        chk("rst_WeA", 32'(ram_WeA), 0);
        chk("rst_WeB", 32'(ram_WeB), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addrA", 32'(ram_addrA), 0);
        chk("rst_SPM", 32'(ram_SPM), 0);
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            if (c == 0) Clr = 1'b0;
            for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'($urandom), 8'h00);
            evaluate();
            chk("fair_pair", 32'(gnt), (c % 2) ? 32'hC : 32'h3);
        end
        next_cycle();
        req = '0;
        evaluate();
        next_cycle();
        set_req(0, 1'b1, 8'h10, 8'hA5);
        evaluate();
        chk("wr_gnt0", 32'(gnt[0]), 1);
        next_cycle();
        evaluate();
        next_cycle();
        set_req(0, 1'b0, 8'h10, 8'h00);
        evaluate();
        chk("rd_gnt0", 32'(gnt[0]), 1);
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            evaluate();
        end
        next_cycle();
        set_req(1, 1'b1, 8'h20, 8'h11);
        set_req(2, 1'b1, 8'h20, 8'h22);
        evaluate();
        chk("conf_c1", 32'(gnt), 32'h2);
        next_cycle();
        evaluate();
        chk("conf_c2", 32'(gnt), 32'h4);
        next_cycle();
        set_req(1, 1'b0, 8'h20, 8'h00);
        evaluate();
        chk("conf_rd", 32'(m_mem[8'h20]), 32'h22);
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            evaluate();
        end
        next_cycle();
        set_req(0, 1'b1, 8'h30, 8'h77);
        evaluate();
        next_cycle();
        set_req(0, 1'b0, 8'h30, 8'h00);
        set_req(3, 1'b1, 8'h30, 8'h99);
        evaluate();
        chk("mix_gnt", 32'(gnt), 32'h9);
        mix_chk = 1'b1;
        next_cycle();
        evaluate();
        next_cycle();
        set_req(0, 1'b0, 8'h30, 8'h00);
        evaluate();
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            evaluate();
        end
        next_cycle();
        set_req(2, 1'b0, 8'h30, 8'h00);
        evaluate();
        chk("mf_gnt2", 32'(gnt[2]), 1);
        next_cycle();
        Clr = 1'b1;
        for (int i = 0; i < N; i++) begin
            q_due[i].delete();
            q_dat[i].delete();
        end
        evaluate();
        next_cycle();
        evaluate();
        chk("mf_WeA", 32'(ram_WeA), 0);
        chk("mf_rvalid", 32'(rvalid), 0);
        next_cycle();
        Clr = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'($urandom), 8'h00);
        evaluate();
        chk("post_rst_gnt", 32'(gnt), 32'h3);
        next_cycle();
        req = '0;
        evaluate();
        for (int c = 0; c < 300; c++) begin
            next_cycle();
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if ($urandom % 3 == 0) set_req(i, 1'($urandom), 8'h40 + 8'($urandom % 4), 8'($urandom));
                end else if ($urandom % 16 == 0) req[i] = 1'b0;
            end
            evaluate();
        end
        next_cycle();
        req = '0;
        evaluate();
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            evaluate();
        end
        for (int i = 0; i < N; i++) chk($sformatf("drain%0d", i), q_due[i].size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
